// File: rtl/alu_op_issue.sv
// ID/EX issue register: decodes RV32I ALU/load/store/branch fields into a 4-bit ALU op plus operands.
// Define ISSUE_SKID_EN to get a two-entry skid buffer with a registered in_ready.
module alu_op_issue #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [RD_W-1:0] out_rd,
  output logic            illegal
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int EW = 1 + 4 + 2*XLEN + RD_W;

  logic            dec_ill;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_b;
  logic [XLEN-1:0] shamt;
  logic [EW-1:0]   entry_in;
  logic            in_fire;
  logic            out_valid_reg;
  logic [EW-1:0]   out_data_reg;

  assign shamt = {{(XLEN-5){1'b0}}, in_imm[4:0]};

  always_comb begin
    dec_ill = 1'b0;
    dec_op  = ALU_ADD;
    dec_b   = in_rs2;
    case (in_opcode)
      OPC_OP: begin
        case (in_funct3)
          3'b000:  dec_op = in_funct7b5 ? ALU_SUB : ALU_ADD;
          3'b001:  dec_op = ALU_SLL;
          3'b010:  dec_op = ALU_SLT;
          3'b011:  dec_op = ALU_SLTU;
          3'b100:  dec_op = ALU_XOR;
          3'b101:  dec_op = in_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
        dec_ill = in_funct7b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
      end
      OPC_OPIMM: begin
        // For immediates, bit 30 is only meaningful on shifts; elsewhere it is just imm[10].
        dec_b = in_imm;
        case (in_funct3)
          3'b000:  dec_op = ALU_ADD;
          3'b001: begin
            dec_op  = ALU_SLL;
            dec_b   = shamt;
            dec_ill = in_funct7b5;
          end
          3'b010:  dec_op = ALU_SLT;
          3'b011:  dec_op = ALU_SLTU;
          3'b100:  dec_op = ALU_XOR;
          3'b101: begin
            dec_op = in_funct7b5 ? ALU_SRA : ALU_SRL;
            dec_b  = shamt;
          end
          3'b110:  dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE: dec_b = in_imm;
      OPC_BRANCH: begin
        case (in_funct3[2:1])
          2'b00:   dec_op = ALU_SUB;
          2'b01:   dec_ill = 1'b1;
          2'b10:   dec_op = ALU_SLT;
          default: dec_op = ALU_SLTU;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign entry_in = dec_ill ? {1'b1, ALU_ADD, {XLEN{1'b0}}, {XLEN{1'b0}}, in_rd}
                            : {1'b0, dec_op, in_rs1, dec_b, in_rd};

  assign in_fire   = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign {illegal, alu_op, op_a, op_b, out_rd} = out_data_reg;

`ifdef ISSUE_SKID_EN
  logic          skid_valid_reg;
  logic [EW-1:0] skid_data_reg;

  assign in_ready = !skid_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!out_valid_reg || out_ready) begin
      // Output slot frees up: the parked entry goes first, input is blocked while it is parked.
      if (skid_valid_reg) begin
        out_data_reg   <= skid_data_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (in_fire) begin
        out_data_reg  <= entry_in;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (in_fire) begin
      skid_data_reg  <= entry_in;
      skid_valid_reg <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid_reg || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (in_fire) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= entry_in;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: fixed decode vectors, multi-cycle handshake/flush/reset sequences,
// and randomized traffic against a table-based reference model with an in-order scoreboard.
module tb_alu_op_issue;
  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [6:0] R_T  = 7'b0110011;
  localparam logic [6:0] I_T  = 7'b0010011;
  localparam logic [6:0] LD_T = 7'b0000011;
  localparam logic [6:0] ST_T = 7'b0100011;
  localparam logic [6:0] BR_T = 7'b1100011;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready, in_funct7b5;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1, in_rs2, in_imm, op_a, op_b;
  logic [RD_W-1:0] in_rd, out_rd;
  logic            out_valid, out_ready, illegal;
  logic [3:0]      alu_op;

  alu_op_issue #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_rd(out_rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            ill;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RD_W-1:0] rd;
  } exp_t;

  typedef struct {
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            b5;
    logic [XLEN-1:0] rs1, rs2, imm;
    logic [RD_W-1:0] rd;
    logic            ill;
    logic [3:0]      op;
    logic [XLEN-1:0] a, b;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vecs[18];
  logic [3:0] plain_tab[8];
  logic [3:0] br_tab[4];
  int         n_vec = 0;
  int         n_bad = 0;
  logic       last_in_fire;
  logic [RD_W-1:0] seq_rd;
  logic [XLEN-1:0] seq_a;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference decode: mnemonic tables indexed by funct3, then the illegal substitution.
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                                 input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                 input logic [XLEN-1:0] imm, input logic [RD_W-1:0] rd);
    exp_t e;
    bit ok = 1'b1;
    logic [3:0] op = 4'b0010;
    logic [XLEN-1:0] b = rs2;
    if (opc == R_T) begin
      if (!b5) op = plain_tab[f3];
      else if (f3 == 3'd0) op = 4'b0110;
      else if (f3 == 3'd5) op = 4'b1001;
      else ok = 1'b0;
    end else if (opc == I_T) begin
      b  = (f3 == 3'd1 || f3 == 3'd5) ? (imm & 32'h1f) : imm;
      op = (f3 == 3'd5 && b5) ? 4'b1001 : plain_tab[f3];
      if (f3 == 3'd1 && b5) ok = 1'b0;
    end else if (opc == LD_T || opc == ST_T) begin
      b = imm;
    end else if (opc == BR_T) begin
      op = br_tab[f3 >> 1];
      if ((f3 >> 1) == 3'd1) ok = 1'b0;
    end else begin
      ok = 1'b0;
    end
    if (ok) begin
      e.ill = 1'b0; e.op = op; e.a = rs1; e.b = b;
    end else begin
      e.ill = 1'b1; e.op = 4'b0010; e.a = '0; e.b = '0;
    end
    e.rd = rd;
    return e;
  endfunction

  // Scoreboard step, sampled mid-cycle: checks the held output, then applies this cycle's transfers.
  task automatic mon();
    exp_t e;
    logic o_fire, i_fire;
    if (reset) begin
      exp_q.delete();
      last_in_fire = 1'b0;
      return;
    end
    chk("sb_out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
`ifdef ISSUE_SKID_EN
    chk("sb_in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
`else
    chk("sb_in_ready", 128'(in_ready), 128'(exp_q.size() == 0 || out_ready));
`endif
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("sb_entry", 128'({illegal, alu_op, op_a, op_b, out_rd}),
          128'({e.ill, e.op, e.a, e.b, e.rd}));
    end
    o_fire = out_valid && out_ready;
    i_fire = in_valid && in_ready;
    last_in_fire = i_fire && !flush;
    if (flush) exp_q.delete();
    else begin
      if (o_fire && exp_q.size() > 0) void'(exp_q.pop_front());
      if (i_fire) exp_q.push_back(model(in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, in_rd));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                        input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                        input logic [XLEN-1:0] imm, input logic [RD_W-1:0] rd);
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7b5 = b5;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
  endtask

  task automatic setv(input int i, input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                      input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] imm,
                      input logic [RD_W-1:0] rd, input logic ill, input logic [3:0] op,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    vecs[i].opc = opc; vecs[i].f3 = f3; vecs[i].b5 = b5; vecs[i].rs1 = rs1; vecs[i].rs2 = rs2;
    vecs[i].imm = imm; vecs[i].rd = rd; vecs[i].ill = ill; vecs[i].op = op; vecs[i].a = a; vecs[i].b = b;
  endtask

  task automatic seq_next();
    seq_rd = seq_rd + 5'd1;
    seq_a  = seq_a + 32'd1;
    set_in(R_T, 3'd4, 1'b0, seq_a, 32'h55, 32'h0, seq_rd);
  endtask

  initial begin
    plain_tab = '{4'b0010, 4'b0100, 4'b1000, 4'b0111, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    br_tab    = '{4'b0110, 4'b0010, 4'b1000, 4'b0111};

    setv(0,  R_T, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 5'd7, 1'b0, 4'b0110, 32'd10, 32'd3);
    setv(1,  R_T, 3'd0, 1'b0, 32'd5, 32'd9, 32'd0, 5'd1, 1'b0, 4'b0010, 32'd5, 32'd9);
    setv(2,  R_T, 3'd5, 1'b1, 32'h80000000, 32'h23, 32'd0, 5'd2, 1'b0, 4'b1001, 32'h80000000, 32'h23);
    setv(3,  R_T, 3'd2, 1'b1, 32'd4, 32'd4, 32'd0, 5'd3, 1'b1, 4'b0010, 32'd0, 32'd0);
    setv(4,  R_T, 3'd3, 1'b0, 32'd6, 32'd7, 32'd0, 5'd4, 1'b0, 4'b0111, 32'd6, 32'd7);
    setv(5,  I_T, 3'd5, 1'b1, 32'h1234, 32'd0, 32'h405, 5'd5, 1'b0, 4'b1001, 32'h1234, 32'd5);
    setv(6,  I_T, 3'd1, 1'b1, 32'h1234, 32'd0, 32'h403, 5'd6, 1'b1, 4'b0010, 32'd0, 32'd0);
    setv(7,  I_T, 3'd1, 1'b0, 32'd9, 32'd0, 32'hFFFFFFE7, 5'd8, 1'b0, 4'b0100, 32'd9, 32'd7);
    setv(8,  I_T, 3'd0, 1'b1, 32'd9, 32'd0, 32'hFFFFFC00, 5'd9, 1'b0, 4'b0010, 32'd9, 32'hFFFFFC00);
    setv(9,  I_T, 3'd4, 1'b0, 32'd1, 32'd0, 32'h0F0, 5'd10, 1'b0, 4'b0011, 32'd1, 32'h0F0);
    setv(10, ST_T, 3'd2, 1'b0, 32'd100, 32'd77, 32'd8, 5'd11, 1'b0, 4'b0010, 32'd100, 32'd8);
    setv(11, BR_T, 3'd6, 1'b0, 32'd1, 32'd2, 32'd0, 5'd12, 1'b0, 4'b0111, 32'd1, 32'd2);
    setv(12, BR_T, 3'd1, 1'b0, 32'd3, 32'd4, 32'd0, 5'd13, 1'b0, 4'b0110, 32'd3, 32'd4);
    setv(13, BR_T, 3'd4, 1'b0, 32'd5, 32'd6, 32'd0, 5'd14, 1'b0, 4'b1000, 32'd5, 32'd6);
    setv(14, BR_T, 3'd2, 1'b0, 32'd5, 32'd6, 32'd0, 5'd15, 1'b1, 4'b0010, 32'd0, 32'd0);
    setv(15, 7'b1111111, 3'd0, 1'b0, 32'd5, 32'd6, 32'd8, 5'd31, 1'b1, 4'b0010, 32'd0, 32'd0);
    setv(16, R_T, 3'd7, 1'b0, 32'hF0, 32'h3C, 32'd0, 5'd16, 1'b0, 4'b0000, 32'hF0, 32'h3C);
    setv(17, R_T, 3'd6, 1'b0, 32'hF0, 32'h3C, 32'd0, 5'd17, 1'b0, 4'b0001, 32'hF0, 32'h3C);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_rd = '0;
    last_in_fire = 1'b0; seq_rd = '0; seq_a = '0;
    #3;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_outputs", 128'({illegal, alu_op, op_a, op_b, out_rd}), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'(1));

    // Decode table, one instruction per cycle with the ALU always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].opc, vecs[i].f3, vecs[i].b5, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].rd);
      tick();
      in_valid = 1'b0;
      chk("vec_valid", 128'(out_valid), 128'(1));
      chk("vec_entry", 128'({illegal, alu_op, op_a, op_b, out_rd}),
          128'({vecs[i].ill, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd}));
      $display("vec %0d: op=%b a=%0h b=%0h rd=%0d ill=%0b", i, alu_op, op_a, op_b, out_rd, illegal);
    end
    tick();

    // Back-to-back loads at full throughput.
    for (int i = 0; i < 8; i++) begin
      set_in(LD_T, 3'd2, 1'b0, 32'h100, $urandom, 32'(4*i), 5'(i));
      tick();
      chk("load_valid", 128'(out_valid), 128'(1));
      chk("load_op", 128'(alu_op), 128'(4'b0010));
      chk("load_b", 128'(op_b), 128'(4*i));
      $display("load %0d: op_b=%0d", i, op_b);
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Stall pattern 1,1,0,0,1 with continuous in_valid; the scoreboard catches loss or duplication.
    seq_next();
    begin
      logic pat[7];
      pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int k = 0; k < 7; k++) begin
        out_ready = pat[k];
        tick();
        if (k == 2) chk("stall_in_ready", 128'(in_ready), 128'(0));
        if (last_in_fire) seq_next();
        $display("stall cycle %0d: out_valid=%0b rd=%0d in_ready=%0b", k, out_valid, out_rd, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("stall_drained", 128'(out_valid), 128'(0));

    // Fill while stalled, then flush together with a new input.
    out_ready = 1'b0;
    seq_next();
    for (int k = 0; k < 3; k++) begin
      tick();
      if (last_in_fire) seq_next();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_clear", 128'(out_valid), 128'(0));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("flush_nothing_later", 128'(out_valid), 128'(0));
    $display("flush sequence done");

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    seq_next();
    for (int k = 0; k < 3; k++) begin
      tick();
      if (last_in_fire) seq_next();
    end
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", 128'(out_valid), 128'(0));
    chk("async_reset_outputs", 128'({illegal, alu_op, op_a, op_b, out_rd}), 128'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_in_ready", 128'(in_ready), 128'(1));
    $display("async reset sequence done");

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      logic [6:0] opc;
      case ($urandom_range(0, 5))
        0: opc = R_T;
        1: opc = I_T;
        2: opc = LD_T;
        3: opc = ST_T;
        4: opc = BR_T;
        default: opc = 7'($urandom);
      endcase
      set_in(opc, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("random_drained", 128'(out_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Producer side of the ALU operation interface: turns decoded instruction fields into a registered 4-bit ALU opcode plus operand A/B.
- Sits between the decode stage and the ALU as the ID/EX issue register.
- Valid/ready handshake on both sides; synchronous flush for branch mispredicts.
- Output opcode encoding is the ALU's: and 0000, or 0001, add 0010, xor 0011, sll 0100, srl 0101, sub 0110, sltu 0111, slt 1000, sra 1001.

Parameters:
- XLEN, 32, operand width.
- RD_W, 5, destination-register tag width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all held entries.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  issue can accept this cycle.
- in_opcode  in  7  instruction[6:0].
- in_funct3  in  3  instruction[14:12].
- in_funct7b5  in  1  instruction[30].
- in_rs1  in  XLEN  rs1 data.
- in_rs2  in  XLEN  rs2 data.
- in_imm  in  XLEN  sign-extended immediate.
- in_rd  in  RD_W  destination tag.
- out_valid  out  1  issued op valid.
- out_ready  in  1  ALU stage consumes.
- alu_op  out  4  ALU opcode.
- op_a  out  XLEN  operand A.
- op_b  out  XLEN  operand B.
- out_rd  out  RD_W  destination tag.
- illegal  out  1  entry failed decode.

Behaviour:
- Reset (async): out_valid=0, alu_op=0000, op_a=0, op_b=0, out_rd=0, illegal=0, all internal valids cleared. in_ready=1 once reset deasserts.
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle. Outputs are held stable while out_valid & !out_ready.
- Decode, R-type (0110011), B=rs2:
  - funct3 000: add if b5=0, sub if b5=1.
  - 001 sll; 010 slt; 011 sltu; 100 xor.
  - 101: srl if b5=0, sra if b5=1.
  - 110 or; 111 and.
  - b5=1 with any funct3 other than 000/101 -> illegal.
- Decode, I-ALU (0010011), B=imm:
  - Same mapping as R-type, except funct3 000 is always add.
  - funct3 001/101: B={zeros, imm[4:0]}.
  - 001 with b5=1 -> illegal.
- Decode, load (0000011) and store (0100011): add, B=imm.
- Decode, branch (1100011), B=rs2:
  - 000/001 -> sub.
  - 100/101 -> slt.
  - 110/111 -> sltu.
  - 010/011 -> illegal.
- Decode, any other opcode -> illegal.
- Operand A = rs1 in all legal cases.
- Illegal entry: issued with illegal=1, alu_op=0010, op_a=0, op_b=0, and out_rd passed through. The handshake is unchanged.
- Arithmetic: no arithmetic in this block. Operands are passed unmodified apart from the shift-amount masking.
- Flush:
  - Next edge clears out_valid and all skid entries; any same-cycle input transfer is dropped.
  - A flush that coincides with an output transfer still counts as consumed.
  - Data registers may keep stale values.
- Simultaneous input and output transfer with one entry held: the new entry replaces it with no bubble, giving full throughput.
- Reset mid-transfer: state clears immediately; no partial entry survives.

Optional Feature:
- Macro: ISSUE_SKID_EN.
- Defined: two-entry skid buffer.
  - in_ready is driven straight from a flop, is 1 when the skid entry is empty, and has no combinational path from out_ready.
  - If out_ready drops while an input transfer completes, the entry is parked in the skid slot and in_ready falls next cycle.
  - The skid entry is issued before any new input (FIFO order).
- Undefined: single register; in_ready = !out_valid | out_ready (combinational).
- Both variants must deliver identical transaction order and content.

Test Plan:
1. Reset, then R-type opcode 0110011, funct3 000, b5=1, rs1=10, rs2=3, rd=7 -> next cycle out_valid=1, alu_op=0110, op_a=10, op_b=3, out_rd=7, illegal=0.
2. I-type 0010011, funct3 101, b5=1, imm=0x405 -> alu_op=1001, op_b=5. Same with funct3 001, b5=1 -> illegal=1, alu_op=0010, op_a=0, op_b=0.
3. Branch funct3 110, rs1=1, rs2=2 -> alu_op=0111. Branch funct3 010 -> illegal=1. Opcode 1111111 -> illegal=1.
4. Back-to-back stream of 8 loads, imm=4*i, with out_ready=1 -> 8 consecutive out_valid cycles, alu_op=0010, op_b=0,4,...,28 in order.
5. out_ready toggling 1,0,0,1 with continuous in_valid -> no loss or duplication, order preserved. With ISSUE_SKID_EN, in_ready is 0 the cycle after the stall begins.
6. Two entries held, flush=1 concurrent with in_valid=1 -> next cycle out_valid=0 and no entry emerges later. Async reset mid-stall -> all outputs zero without waiting for a clock edge.
